// File: rtl/fp_align_pipe.sv
// rtl/fp_align_pipe.sv - two-stage floating-point operand alignment pipeline
// S1 picks the larger effective exponent and forms hidden-bit words; S2 shifts the smaller one with sticky.
module fp_align_pipe #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int AW     = MANT_W + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [MANT_W-1:0] b_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [AW-1:0]     a_al,
  output logic [AW-1:0]     b_al,
  output logic              shifted_b,
  output logic [EXP_W-1:0]  shift_amt
);

  logic              s1_valid;
  logic              s2_valid;
  logic              s2_load;

  logic [EXP_W-1:0]  a_eff;
  logic [EXP_W-1:0]  b_eff;
  logic [AW-1:0]     a_word;
  logic [AW-1:0]     b_word;
  logic              a_larger;

  logic [AW-1:0]     s1_keep;
  logic [AW-1:0]     s1_shw;
  logic [EXP_W-1:0]  s1_exp;
  logic [EXP_W-1:0]  s1_d;
  logic              s1_sb;

  logic [AW-1:0]     shifted;
  logic              lost;

  // Output stage is the only place backpressure enters; S1 frees up whenever S2 can load.
  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign out_valid = s2_valid;

  // Denormals (biased exponent 0) share the scale of exponent 1 but have no hidden bit.
  always_comb begin
    a_eff    = (a_exp == '0) ? EXP_W'(1) : a_exp;
    b_eff    = (b_exp == '0) ? EXP_W'(1) : b_exp;
    a_word   = {(a_exp != '0), a_mant, 3'b000};
    b_word   = {(b_exp != '0), b_mant, 3'b000};
    a_larger = a_eff > b_eff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_keep  <= '0;
      s1_shw   <= '0;
      s1_exp   <= '0;
      s1_d     <= '0;
      s1_sb    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        if (a_larger) begin
          s1_keep <= a_word;
          s1_shw  <= b_word;
          s1_exp  <= a_eff;
          s1_d    <= a_eff - b_eff;
          s1_sb   <= 1'b1;
        end else begin
          s1_keep <= b_word;
          s1_shw  <= a_word;
          s1_exp  <= b_eff;
          s1_d    <= b_eff - a_eff;
          s1_sb   <= 1'b0;
        end
      end
    end
  end

  // Bits below position d fall off the end; once d >= AW every bit is lost and the shift yields zero.
  always_comb begin
    lost = 1'b0;
    for (int i = 0; i < AW; i++) begin
      if (i < int'(s1_d)) lost = lost | s1_shw[i];
    end
    shifted    = s1_shw >> s1_d;
    shifted[0] = shifted[0] | lost;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      out_exp   <= '0;
      a_al      <= '0;
      b_al      <= '0;
      shifted_b <= 1'b0;
      shift_amt <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_exp   <= s1_exp;
        shifted_b <= s1_sb;
        shift_amt <= s1_d;
        a_al      <= s1_sb ? s1_keep : shifted;
        b_al      <= s1_sb ? shifted : s1_keep;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_pipe.sv
// tb/tb_fp_align_pipe.sv - scoreboard bench for fp_align_pipe at default and narrow widths
// Expected results come from an arithmetic alignment model; a monitor pops them on each output transfer.
module tb_fp_align_pipe;

  typedef struct {
    longint e;
    longint a;
    longint b;
    longint s;
    longint d;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic        iv0, ir0, ov0, or0, sb0;
  logic [7:0]  ae0, be0, oe0, sa0;
  logic [22:0] am0, bm0;
  logic [26:0] aa0, ba0;

  logic        iv1, ir1, ov1, or1, sb1;
  logic [4:0]  ae1, be1, oe1, sa1;
  logic [9:0]  am1, bm1;
  logic [13:0] aa1, ba1;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_align_pipe dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0),
    .a_exp(ae0), .a_mant(am0), .b_exp(be0), .b_mant(bm0),
    .out_valid(ov0), .out_ready(or0), .out_exp(oe0), .a_al(aa0), .b_al(ba0),
    .shifted_b(sb0), .shift_amt(sa0)
  );

  fp_align_pipe #(.MANT_W(10), .EXP_W(5)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .a_exp(ae1), .a_mant(am1), .b_exp(be1), .b_mant(bm1),
    .out_valid(ov1), .out_ready(or1), .out_exp(oe1), .a_al(aa1), .b_al(ba1),
    .shifted_b(sb1), .shift_amt(sa1)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic longint shr(input longint w, input longint d, input int aw);
    longint r;
    if (d >= aw) return (w != 0) ? 1 : 0;
    r = w >> d;
    if ((w & ((64'sd1 <<< d) - 1)) != 0) r = r | 1;
    return r;
  endfunction

  function automatic exp_t model(input int mw, input longint ae, input longint am,
                                 input longint be, input longint bm);
    exp_t r;
    longint ea, eb, wa, wb;
    int aw;
    aw = mw + 4;
    ea = (ae == 0) ? 1 : ae;
    eb = (be == 0) ? 1 : be;
    wa = ((ae != 0) ? (64'sd1 <<< (mw + 3)) : 0) + am * 8;
    wb = ((be != 0) ? (64'sd1 <<< (mw + 3)) : 0) + bm * 8;
    if (ea > eb) begin
      r.e = ea; r.d = ea - eb; r.s = 1; r.a = wa; r.b = shr(wb, r.d, aw);
    end else begin
      r.e = eb; r.d = eb - ea; r.s = 0; r.b = wb; r.a = shr(wa, r.d, aw);
    end
    return r;
  endfunction

  function automatic int pick_a(input int ew);
    int m;
    int mx;
    mx = (1 << ew) - 1;
    m = $urandom_range(0, 7);
    if (m == 0) return 0;
    if (m == 1) return mx;
    return $urandom_range(0, mx);
  endfunction

  function automatic int pick_b(input int ew, input int a);
    int m;
    int mx;
    int v;
    mx = (1 << ew) - 1;
    m = $urandom_range(0, 5);
    if (m == 0) return 0;
    if (m == 1) return a;
    if (m == 2) return mx;
    if (m == 3) begin
      v = a + $urandom_range(0, 8) - 4;
      if (v < 0) v = 0;
      if (v > mx) v = mx;
      return v;
    end
    return $urandom_range(0, mx);
  endfunction

  task automatic mon_cmp(input string tag, input exp_t x, input longint e, input longint a,
                         input longint b, input longint s, input longint d);
    chk({tag, ".out_exp"}, e, x.e);
    chk({tag, ".a_al"}, a, x.a);
    chk({tag, ".b_al"}, b, x.b);
    chk({tag, ".shifted_b"}, s, x.s);
    chk({tag, ".shift_amt"}, d, x.d);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && ov0 && or0) begin
        if (q0.size() == 0) chk("dut0 unexpected output", 1, 0);
        else begin
          x = q0.pop_front();
          mon_cmp("dut0", x, oe0, aa0, ba0, sb0, sa0);
        end
      end
      if (!reset && ov1 && or1) begin
        if (q1.size() == 0) chk("dut1 unexpected output", 1, 0);
        else begin
          x = q1.pop_front();
          mon_cmp("dut1", x, oe1, aa1, ba1, sb1, sa1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive0(input int ae, input int am, input int be, input int bm);
    ae0 = 8'(ae); am0 = 23'(am); be0 = 8'(be); bm0 = 23'(bm);
    iv0 = 1'b1;
  endtask

  task automatic dir0(input int ae, input int am, input int be, input int bm,
                      input longint e, input longint a, input longint b,
                      input longint s, input longint d);
    exp_t x;
    @(negedge clk);
    or0 = 1'b1;
    drive0(ae, am, be, bm);
    #1;
    chk("directed in_ready", ir0, 1);
    x.e = e; x.a = a; x.b = b; x.s = s; x.d = d;
    if (ir0) q0.push_back(x);
  endtask

  task automatic push0_if_accepted();
    #1;
    if (iv0 && ir0 && !reset) q0.push_back(model(23, ae0, am0, be0, bm0));
  endtask

  task automatic rand0(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      or0 = ($urandom_range(0, 3) != 0);
      iv0 = ($urandom_range(0, 2) != 0);
      ae0 = 8'(pick_a(8));
      be0 = 8'(pick_b(8, int'(ae0)));
      am0 = 23'($urandom);
      bm0 = 23'($urandom);
      push0_if_accepted();
    end
    @(negedge clk);
    iv0 = 1'b0;
    or0 = 1'b1;
  endtask

  task automatic rand1(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      or1 = ($urandom_range(0, 2) != 0);
      iv1 = ($urandom_range(0, 3) != 0);
      ae1 = 5'(pick_a(5));
      be1 = 5'(pick_b(5, int'(ae1)));
      am1 = 10'($urandom);
      bm1 = 10'($urandom);
      #1;
      if (iv1 && ir1) q1.push_back(model(10, ae1, am1, be1, bm1));
    end
    @(negedge clk);
    iv1 = 1'b0;
    or1 = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    iv0 = 1'b0; or0 = 1'b1; ae0 = '0; am0 = '0; be0 = '0; bm0 = '0;
    iv1 = 1'b0; or1 = 1'b1; ae1 = '0; am1 = '0; be1 = '0; bm1 = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid dut0", ov0, 0);
    chk("reset out_valid dut1", ov1, 0);
    chk("reset a_al dut0", aa0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready after reset dut0", ir0, 1);
    chk("in_ready after reset dut1", ir1, 1);

    // Directed cases; first one also measures latency into an empty pipe.
    dir0(130, 0, 128, 0, 130, 'h4000000, 'h1000000, 1, 2);
    @(negedge clk);
    iv0 = 1'b0;
    #1 chk("latency out_valid after 1 edge", ov0, 0);
    @(negedge clk);
    #1 chk("latency out_valid after 2 edges", ov0, 1);
    dir0(127, 'h400000, 127, 'h400000, 127, 'h6000000, 'h6000000, 0, 0);
    dir0(168, 0, 128, 'h7FFFFF, 168, 'h4000000, 'h0000001, 1, 40);
    dir0(1, 0, 0, 'h000001, 1, 'h4000000, 'h0000008, 0, 0);
    dir0(100, 'h7FFFFF, 103, 0, 103, 'h0FFFFFF, 'h4000000, 0, 3);
    dir0(153, 0, 128, 1, 153, 'h4000000, 'h0000003, 1, 25);
    dir0(151, 0, 124, 0, 151, 'h4000000, 'h0000001, 1, 27);
    dir0(255, 0, 254, 0, 255, 'h4000000, 'h2000000, 1, 1);
    @(negedge clk);
    iv0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("directed drained", q0.size(), 0);

    // Backpressure: two pairs fill the pipe, third waits until out_ready returns.
    @(negedge clk);
    or0 = 1'b0;
    drive0(10, 'h123, 20, 'h456);
    #1 chk("bp in_ready pair1", ir0, 1);
    if (ir0) q0.push_back(model(23, ae0, am0, be0, bm0));
    @(negedge clk);
    drive0(200, 'h7ABCDE, 199, 'h000F00);
    #1 chk("bp in_ready pair2", ir0, 1);
    if (ir0) q0.push_back(model(23, ae0, am0, be0, bm0));
    @(negedge clk);
    drive0(0, 'h3FFFFF, 30, 'h1);
    #1 chk("bp in_ready full", ir0, 0);
    @(negedge clk);
    #1 chk("bp in_ready still full", ir0, 0);
    chk("bp out_valid stalled", ov0, 1);
    @(negedge clk);
    or0 = 1'b1;
    #1 chk("bp in_ready released", ir0, 1);
    if (ir0) q0.push_back(model(23, ae0, am0, be0, bm0));
    @(negedge clk);
    iv0 = 1'b0;
    #1 chk("bp second result consecutive", ov0, 1);
    @(negedge clk);
    #1 chk("bp third result consecutive", ov0, 1);
    @(negedge clk);
    #1 chk("bp pipe empty", ov0, 0);
    chk("bp none lost", q0.size(), 0);

    // Reset with two pairs in flight and a third offered during reset.
    @(negedge clk);
    or0 = 1'b0;
    drive0(140, 'h55555, 135, 'h2AAAA);
    @(negedge clk);
    drive0(90, 'h1, 95, 'h7FFFFF);
    @(negedge clk);
    chk("pre-reset out_valid", ov0, 1);
    reset = 1'b1;
    drive0(77, 'h1234, 70, 'h4321);
    @(negedge clk);
    reset = 1'b0;
    iv0 = 1'b0;
    q0.delete();
    chk("reset clears out_valid", ov0, 0);
    chk("reset clears out_exp", oe0, 0);
    chk("reset clears a_al", aa0, 0);
    chk("reset clears b_al", ba0, 0);
    chk("reset clears shifted_b", sb0, 0);
    chk("reset clears shift_amt", sa0, 0);
    chk("in_ready after mid-flight reset", ir0, 1);
    or0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset discarded input", ov0, 0);

    fork
      rand0(400);
      rand1(400);
    join
    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    chk("random drain dut0", q0.size(), 0);
    chk("random drain dut1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
